// File: rtl/restoring_div_16x8.sv
// 16/8 unsigned restoring divider: one quotient bit per clock, MSB first, IDLE/RUN/DONE FSM.
// Define DIV_ZERO_CHECK_EN to add the divzero port and a one-cycle early exit for b == 0.
module restoring_div_16x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [7:0]  b,
  output logic [15:0] q,
  output logic [7:0]  r,
  output logic        busy,
  output logic        ready
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic        divzero
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [15:0] dq_q;
  logic [7:0]  div_q;
  logic [8:0]  pr_q;
  logic [4:0]  cnt_q;
  logic [15:0] q_q;
  logic [7:0]  r_q;
  logic        busy_q;
  logic        ready_q;
  logic        dz_q;

  logic [8:0]  pr_shift;
  logic        fits;
  logic [8:0]  pr_d;
  logic [15:0] dq_d;

  // Dividend bits leave the top of dq_q while quotient bits enter at the bottom.
  always_comb begin
    pr_shift = {pr_q[7:0], dq_q[15]};
    fits     = (pr_shift >= {1'b0, div_q});
    pr_d     = fits ? (pr_shift - {1'b0, div_q}) : pr_shift;
    dq_d     = {dq_q[14:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dq_q    <= '0;
      div_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          busy_q <= 1'b0;
          if (start) begin
            dq_q  <= a;
            div_q <= b;
            cnt_q <= '0;
            pr_q  <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (b == 8'd0) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              dz_q    <= 1'b1;
              q_q     <= 16'hFFFF;
              r_q     <= a[7:0];
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
`else
            state_q <= RUN;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          pr_q  <= pr_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q + 5'd1;
          // Results are published only on the edge that completes the last iteration.
          if (cnt_q == 5'd15) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            q_q     <= dq_d;
            r_q     <= pr_d[7:0];
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q     = q_q;
  assign r     = r_q;
  assign busy  = busy_q;
  assign ready = ready_q;
`ifdef DIV_ZERO_CHECK_EN
  assign divzero = dz_q;
`endif

endmodule

// File: tb/tb_restoring_div_16x8.sv
// Scoreboard bench for restoring_div_16x8: expected results queued at start, popped at ready.
module tb_restoring_div_16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [7:0]  b;
  logic [15:0] q;
  logic [7:0]  r;
  logic        busy;
  logic        ready;
`ifdef DIV_ZERO_CHECK_EN
  logic        divzero;
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  restoring_div_16x8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .ready (ready)
`ifdef DIV_ZERO_CHECK_EN
    ,
    .divzero (divzero)
`endif
  );

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic exp_t model(input logic [15:0] aa, input logic [7:0] bb);
    exp_t        e;
    logic [15:0] rem;
    if (bb == 8'd0) begin
      e.q = 16'hFFFF;
      e.r = aa[7:0];
    end else begin
      e.q = aa / {8'd0, bb};
      rem = aa % {8'd0, bb};
      e.r = rem[7:0];
    end
    return e;
  endfunction

  // Drive a one-cycle start; returns at the negedge of the first cycle after the accepting edge.
  task automatic launch(input logic [15:0] aa, input logic [7:0] bb);
    @(negedge clk);
    a     = aa;
    b     = bb;
    start = 1'b1;
    sb.push_back(model(aa, bb));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (q !== 16'd0) begin tests_failed++; $display("FAIL reset_q: got %0d expected 0", q); end
    tests_run++;
    if (r !== 8'd0) begin tests_failed++; $display("FAIL reset_r: got %0d expected 0", r); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", ready); end
`ifdef DIV_ZERO_CHECK_EN
    tests_run++;
    if (divzero !== 1'b0) begin tests_failed++; $display("FAIL reset_divzero: got %b expected 0", divzero); end
`endif
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_divide(input logic [15:0] aa, input logic [7:0] bb);
    int          cyc;
    int          busy_cnt;
    int          glitches;
    int          lat;
    logic [15:0] prev_q;
    exp_t        e;
    lat      = (bb == 8'd0 && DZ_EN) ? 1 : 17;
    prev_q   = q;
    launch(aa, bb);
    cyc      = 1;
    busy_cnt = 0;
    glitches = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (q !== prev_q) glitches++;
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_%0d_%0d timeout: no ready within %0d cycles", aa, bb, cyc);
    end else if (cyc != lat) begin
      tests_failed++;
      $display("FAIL div_%0d_%0d latency: got %0d expected %0d", aa, bb, cyc, lat);
    end
    tests_run++;
    if (busy_cnt != lat - 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_%0d_%0d busy: got %0d cycles (busy at ready=%b) expected %0d", aa, bb, busy_cnt, busy, lat - 1);
    end
    tests_run++;
    if (glitches != 0) begin
      tests_failed++;
      $display("FAIL div_%0d_%0d q_glitch: got %0d changes during run expected 0", aa, bb, glitches);
    end
    e = sb.pop_front();
    tests_run++;
    if (q !== e.q || r !== e.r) begin
      tests_failed++;
      $display("FAIL div_%0d_%0d result: got q=%0d r=%0d expected q=%0d r=%0d", aa, bb, q, r, e.q, e.r);
    end
`ifdef DIV_ZERO_CHECK_EN
    tests_run++;
    if (divzero !== (bb == 8'd0)) begin
      tests_failed++;
      $display("FAIL div_%0d_%0d divzero: got %b expected %b", aa, bb, divzero, (bb == 8'd0));
    end
`endif
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b0 || q !== e.q || r !== e.r) begin
      tests_failed++;
      $display("FAIL div_%0d_%0d hold: got ready=%b q=%0d r=%0d expected ready=0 q=%0d r=%0d", aa, bb, ready, q, r, e.q, e.r);
    end
    $display("[TB] divide a=%0d b=%0d -> q=%0d r=%0d after %0d cycles", aa, bb, q, r, cyc);
  endtask

  task automatic test_back_to_back;
    int   cyc;
    exp_t e;
    launch(16'd168, 8'd12);
    cyc = 1;
    while (ready !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    tests_run++;
    if (cyc != 17) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d expected 17", cyc); end
    e = sb.pop_front();
    tests_run++;
    if (q !== e.q || r !== e.r) begin
      tests_failed++;
      $display("FAIL b2b_first_result: got q=%0d r=%0d expected q=%0d r=%0d", q, r, e.q, e.r);
    end
    $display("[TB] b2b first a=168 b=12 -> q=%0d r=%0d", q, r);
    a     = 16'd110;
    b     = 8'd11;
    start = 1'b1;
    sb.push_back(model(16'd110, 8'd11));
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (ready !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    tests_run++;
    if (cyc != 17) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d expected 17", cyc); end
    e = sb.pop_front();
    tests_run++;
    if (q !== e.q || r !== e.r) begin
      tests_failed++;
      $display("FAIL b2b_second_result: got q=%0d r=%0d expected q=%0d r=%0d", q, r, e.q, e.r);
    end
    $display("[TB] b2b second a=110 b=11 -> q=%0d r=%0d", q, r);
    test_divide(16'd225, 8'd15);
  endtask

  task automatic test_ignore_start;
    int   cyc;
    int   extra;
    exp_t e;
    launch(16'd1000, 8'd7);
    cyc = 1;
    while (ready !== 1'b1 && cyc < 40) begin
      if (cyc == 5) begin
        start = 1'b1;
        a     = 16'd5;
        b     = 8'd200;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests_run++;
    if (cyc != 17) begin tests_failed++; $display("FAIL ignore_latency: got %0d expected 17", cyc); end
    e = sb.pop_front();
    tests_run++;
    if (q !== e.q || r !== e.r) begin
      tests_failed++;
      $display("FAIL ignore_result: got q=%0d r=%0d expected q=%0d r=%0d", q, r, e.q, e.r);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready === 1'b1 || busy === 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0) begin tests_failed++; $display("FAIL ignore_extra_activity: got %0d active cycles expected 0", extra); end
    $display("[TB] start during run ignored, result q=%0d r=%0d", q, r);
  endtask

  task automatic test_reset_mid_run;
    int   pulses;
    exp_t e;
    launch(16'd54, 8'd9);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (q !== 16'd0 || r !== 8'd0 || busy !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got q=%0d r=%0d busy=%b ready=%b expected all 0", q, r, busy, ready);
    end
    e = sb.pop_back();
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin tests_failed++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses); end
    $display("[TB] reset mid-run aborted request a=54 b=9 (discarded q=%0d)", e.q);
    test_divide(16'd54, 8'd9);
  endtask

  initial begin
    test_reset();
    test_divide(16'd54, 8'd9);
    test_divide(16'd65535, 8'd1);
    test_divide(16'd65535, 8'd255);
    test_divide(16'd1000, 8'd7);
    test_divide(16'd5, 8'd200);
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_divide(16'd300, 8'd0);
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
